// File: rtl/ntt_pkg.sv
// Shared NTT constants for Q = Q_K*2^Q_M + 1 and the Montgomery multiplier state type.
package ntt_pkg;

   localparam int Q_M        = 8;
   localparam int Q_K        = 13;
   localparam int Q          = Q_K * (2 ** Q_M) + 1;
   localparam int DATA_WIDTH = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mo_mul_iter_state_e;

endpackage

// File: rtl/mo_mul_digit.sv
// One radix-2^BPC Montgomery digit step: S' = (S + a*d + u*Q) >> BPC, purely combinational.
module mo_mul_digit
   import ntt_pkg::*;
#(
   parameter int BPC = 1
) (
   input  logic [DATA_WIDTH+1:0] s,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [BPC-1:0]        d,
   output logic [DATA_WIDTH+1:0] s_next
);

   localparam int TW = DATA_WIDTH + BPC + 2;

   logic [TW-1:0]  t;
   logic [TW-1:0]  v;
   logic [BPC-1:0] u;

   // -Q^-1 mod 2^BPC is all-ones for Q = 1 mod 2^BPC, so u is simply -T mod 2^BPC
   always_comb begin
      t      = TW'(s) + TW'(a) * TW'(d);
      u      = BPC'(~t[BPC-1:0] + BPC'(1));
      v      = t + TW'(u) * TW'(Q);
      s_next = v[TW-1:BPC];
   end

endmodule

// File: rtl/mo_mul_iter.sv
// Iterative Montgomery multiplier: result = a*b*2^-WIDTH mod Q, BPC bits of b per cycle.
// MO_MUL_FULLRED_EN adds a FIX cycle giving a result in [0,Q); otherwise the result is lazily reduced.
module mo_mul_iter
   import ntt_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH,
   parameter int BPC   = 1,
   parameter int TAG_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [WIDTH-1:0]      b,
   input  logic [TAG_W-1:0]      in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic [TAG_W-1:0]      out_tag
);

   localparam int NDIG  = WIDTH / BPC;
   localparam int CNT_W = $clog2(NDIG + 1);
   localparam int SW    = DATA_WIDTH + 2;
   localparam logic [SW-1:0] Q_S = SW'(Q);

   if (!((BPC == 1) || (BPC == 2) || (BPC == 4)) || (WIDTH % BPC != 0) || (BPC > Q_M)) begin : g_bpc_chk
      $error("mo_mul_iter: illegal BPC=%0d for WIDTH=%0d", BPC, WIDTH);
   end

   function automatic logic [SW-1:0] cond_sub(input logic [SW-1:0] s, input logic [SW-1:0] lim);
      return (s >= lim) ? (s - Q_S) : s;
   endfunction

   mo_mul_iter_state_e   state, state_nxt;
   logic [CNT_W-1:0]     cnt_q;
   logic [DATA_WIDTH-1:0] a_q;
   logic [WIDTH-1:0]     b_q;
   logic [TAG_W-1:0]     tag_q;
   logic [SW-1:0]        s_q;
   logic [SW-1:0]        s_step;
   logic                 accept;
   logic                 last;

   assign accept = in_valid && in_ready;
   assign last   = (cnt_q == CNT_W'(NDIG - 1));

   mo_mul_digit #(.BPC(BPC)) u_digit (
      .s      (s_q),
      .a      (a_q),
      .d      (b_q[BPC-1:0]),
      .s_next (s_step)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = RUN;
         RUN: if (last) begin
`ifdef MO_MUL_FULLRED_EN
            state_nxt = FIX;
`else
            state_nxt = DONE;
`endif
         end
         FIX:  state_nxt = DONE;
         DONE: if (out_ready) state_nxt = accept ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
      out_valid = (state == DONE);
   end

   // operand latches carry no reset; they are only read after an accepted transfer
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q   <= a;
         b_q   <= b;
         tag_q <= in_tag;
      end else if (state == RUN) begin
         b_q <= b_q >> BPC;
      end
   end

`ifdef MO_MUL_FULLRED_EN
   logic [SW-1:0] s_red;
   assign s_red = cond_sub(s_q, Q_S);
`else
   // lazy values in [2^DATA_WIDTH, 2Q) are folded once so they fit the result port
   logic [SW-1:0] s_fold;
   assign s_fold = cond_sub(s_step, SW'(1) << DATA_WIDTH);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_q     <= '0;
         cnt_q   <= '0;
         result  <= '0;
         out_tag <= '0;
      end else if (accept) begin
         s_q   <= '0;
         cnt_q <= '0;
      end else if (state == RUN) begin
         s_q   <= s_step;
         cnt_q <= cnt_q + CNT_W'(1);
`ifndef MO_MUL_FULLRED_EN
         if (last) begin
            result  <= s_fold[DATA_WIDTH-1:0];
            out_tag <= tag_q;
         end
`endif
      end
`ifdef MO_MUL_FULLRED_EN
      else if (state == FIX) begin
         s_q     <= s_red;
         result  <= s_red[DATA_WIDTH-1:0];
         out_tag <= tag_q;
      end
`endif
   end

endmodule
